// File: rtl/mem_req_issue_if.sv
// Warp-op, splitter-request, completion and status signals of the memory issue stage.
// The slave modport is the issue stage's view; master is the surrounding logic's view.
`timescale 1ns/1ps
interface mem_req_issue_if #(
  parameter int NumRequests      = 4,
  parameter int AddressWidth     = 8,
  parameter int CommonReqIdWidth = 8,
  parameter int NumIds           = 16,
  parameter int TagWidth         = 5
);
  localparam int CntW = $clog2(NumIds + 1);

  logic                                 warp_valid_i;
  logic                                 warp_ready_o;
  logic                                 warp_we_i;
  logic [TagWidth-1:0]                  warp_tag_i;
  logic [NumRequests-1:0]               warp_mask_i;
  logic [NumRequests*AddressWidth-1:0]  warp_base_i;
  logic [AddressWidth-1:0]              warp_imm_i;
  logic [31:0]                          warp_wdata_i;
  logic [31:0]                          warp_width_i;
  logic                                 req_valid_o;
  logic                                 req_ready_i;
  logic                                 req_we_o;
  logic [CommonReqIdWidth-1:0]          req_id_o;
  logic [NumRequests-1:0]               req_addr_valid_o;
  logic [NumRequests*AddressWidth-1:0]  req_addr_o;
  logic [31:0]                          req_wdata_o;
  logic [31:0]                          req_width_o;
  logic                                 done_valid_i;
  logic [CommonReqIdWidth-1:0]          done_id_i;
  logic                                 done_tag_valid_o;
  logic [TagWidth-1:0]                  done_tag_o;
  logic [CntW-1:0]                      outstanding_o;
  logic                                 error_o;

  modport slave (
    input  warp_valid_i, warp_we_i, warp_tag_i, warp_mask_i, warp_base_i, warp_imm_i,
           warp_wdata_i, warp_width_i, req_ready_i, done_valid_i, done_id_i,
    output warp_ready_o, req_valid_o, req_we_o, req_id_o, req_addr_valid_o, req_addr_o,
           req_wdata_o, req_width_o, done_tag_valid_o, done_tag_o, outstanding_o, error_o
  );

  modport master (
    output warp_valid_i, warp_we_i, warp_tag_i, warp_mask_i, warp_base_i, warp_imm_i,
           warp_wdata_i, warp_width_i, req_ready_i, done_valid_i, done_id_i,
    input  warp_ready_o, req_valid_o, req_we_o, req_id_o, req_addr_valid_o, req_addr_o,
           req_wdata_o, req_width_o, done_tag_valid_o, done_tag_o, outstanding_o, error_o
  );
endinterface

// File: rtl/mem_req_issue.sv
// Warp memory-op issue: per-thread address add, request-ID allocation from a free pool, tag return on completion.
// One-cycle registered output with full throughput; stalls while the output is blocked or no ID is free.
`timescale 1ns/1ps
module mem_req_issue #(
  parameter int NumRequests      = 4,
  parameter int AddressWidth     = 8,
  parameter int CommonReqIdWidth = 8,
  parameter int NumIds           = 16,
  parameter int TagWidth         = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_req_issue_if.slave   bus
);
  localparam int IdW  = CommonReqIdWidth;
  localparam int AW   = AddressWidth;
  localparam int CntW = $clog2(NumIds + 1);

  logic [NumIds-1:0]            busy_q, busy_d;
  logic [TagWidth-1:0]          tag_q [NumIds];
  logic [TagWidth-1:0]          tag_d [NumIds];
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic                         req_valid_q, req_valid_d;
  logic                         req_we_q, req_we_d;
  logic [IdW-1:0]               req_id_q, req_id_d;
  logic [NumRequests-1:0]       req_mask_q, req_mask_d;
  logic [NumRequests*AW-1:0]    req_addr_q, req_addr_d;
  logic [31:0]                  req_wdata_q, req_wdata_d;
  logic [31:0]                  req_width_q, req_width_d;
  logic                         done_tag_valid_q, done_tag_valid_d;
  logic [TagWidth-1:0]          done_tag_q, done_tag_d;
  logic                         error_q, error_d;

  logic                         any_free, warp_ready, accept, alloc, done_hit;
  logic [IdW-1:0]               alloc_id;
  logic [NumIds-1:0]            alloc_oh, done_oh;
  logic [TagWidth-1:0]          done_tag_rd;
  logic [NumRequests*AW-1:0]    addr_sum;

  always_comb begin
    alloc_id = '0;
    // Descending scan: the last free index written is the lowest one.
    for (int i = NumIds - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_id = IdW'(i);
    end
    any_free   = |(~busy_q);
    warp_ready = !rst_i && (!req_valid_q || bus.req_ready_i) && (any_free || (bus.warp_mask_i == '0));
    accept     = bus.warp_valid_i && warp_ready;
    alloc      = accept && (bus.warp_mask_i != '0);

    alloc_oh    = '0;
    done_oh     = '0;
    done_hit    = 1'b0;
    done_tag_rd = '0;
    for (int i = 0; i < NumIds; i++) begin
      alloc_oh[i] = alloc && (alloc_id == IdW'(i));
      if (bus.done_valid_i && (bus.done_id_i == IdW'(i)) && busy_q[i]) begin
        done_oh[i]  = 1'b1;
        done_hit    = 1'b1;
        done_tag_rd = tag_q[i];
      end
    end

    for (int i = 0; i < NumRequests; i++) begin
      addr_sum[i*AW +: AW] = bus.warp_base_i[i*AW +: AW] + bus.warp_imm_i;
    end
  end

  always_comb begin
    // Allocation uses the registered bitmap, so a same-cycle free is seen next cycle.
    busy_d = (busy_q | alloc_oh) & ~done_oh;
    cnt_d  = cnt_q + CntW'(alloc) - CntW'(done_hit);
    for (int i = 0; i < NumIds; i++) begin
      tag_d[i] = alloc_oh[i] ? bus.warp_tag_i : tag_q[i];
    end

    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_id_d    = req_id_q;
    req_mask_d  = req_mask_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_width_d = req_width_q;
    if (accept) begin
      req_valid_d = alloc;
    end else if (bus.req_ready_i) begin
      req_valid_d = 1'b0;
    end
    if (alloc) begin
      req_we_d    = bus.warp_we_i;
      req_id_d    = alloc_id;
      req_mask_d  = bus.warp_mask_i;
      req_addr_d  = addr_sum;
      req_wdata_d = bus.warp_wdata_i;
      req_width_d = bus.warp_width_i;
    end

    done_tag_valid_d = done_hit;
    done_tag_d       = done_tag_rd;
    error_d          = bus.done_valid_i && !done_hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q           <= '0;
      cnt_q            <= '0;
      for (int i = 0; i < NumIds; i++) tag_q[i] <= '0;
      req_valid_q      <= 1'b0;
      req_we_q         <= 1'b0;
      req_id_q         <= '0;
      req_mask_q       <= '0;
      req_addr_q       <= '0;
      req_wdata_q      <= '0;
      req_width_q      <= '0;
      done_tag_valid_q <= 1'b0;
      done_tag_q       <= '0;
      error_q          <= 1'b0;
    end else begin
      busy_q           <= busy_d;
      cnt_q            <= cnt_d;
      for (int i = 0; i < NumIds; i++) tag_q[i] <= tag_d[i];
      req_valid_q      <= req_valid_d;
      req_we_q         <= req_we_d;
      req_id_q         <= req_id_d;
      req_mask_q       <= req_mask_d;
      req_addr_q       <= req_addr_d;
      req_wdata_q      <= req_wdata_d;
      req_width_q      <= req_width_d;
      done_tag_valid_q <= done_tag_valid_d;
      done_tag_q       <= done_tag_d;
      error_q          <= error_d;
    end
  end

  assign bus.warp_ready_o     = warp_ready;
  assign bus.req_valid_o      = req_valid_q;
  assign bus.req_we_o         = req_we_q;
  assign bus.req_id_o         = req_id_q;
  assign bus.req_addr_valid_o = req_mask_q;
  assign bus.req_addr_o       = req_addr_q;
  assign bus.req_wdata_o      = req_wdata_q;
  assign bus.req_width_o      = req_width_q;
  assign bus.done_tag_valid_o = done_tag_valid_q;
  assign bus.done_tag_o       = done_tag_q;
  assign bus.outstanding_o    = cnt_q;
  assign bus.error_o          = error_q;
endmodule

// File: tb/tb_mem_req_issue.sv
// Directed bench for mem_req_issue: stimulus pushes expected requests/tags, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_req_issue;
  localparam int NR = 4, AW = 8, IDW = 8, NID = 16, TW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_req_issue_if #(.NumRequests(NR), .AddressWidth(AW), .CommonReqIdWidth(IDW),
                     .NumIds(NID), .TagWidth(TW)) bus();

  mem_req_issue #(.NumRequests(NR), .AddressWidth(AW), .CommonReqIdWidth(IDW),
                  .NumIds(NID), .TagWidth(TW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [NR-1:0]    mask;
    logic [NR*AW-1:0] addr;
    logic             we;
    logic [31:0]      wdata;
    logic [31:0]      width;
  } exp_t;

  exp_t          exp_q[$];
  logic [TW-1:0] tag_exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_valid_o && bus.req_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 64'(bus.req_id_o), 64'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("req_id",    64'(bus.req_id_o),         64'(e.id));
          chk("req_mask",  64'(bus.req_addr_valid_o), 64'(e.mask));
          chk("req_addr",  64'(bus.req_addr_o),       64'(e.addr));
          chk("req_we",    64'(bus.req_we_o),         64'(e.we));
          chk("req_wdata", 64'(bus.req_wdata_o),      64'(e.wdata));
          chk("req_width", 64'(bus.req_width_o),      64'(e.width));
        end
      end
      if (bus.done_tag_valid_o) begin
        if (tag_exp_q.size() == 0) chk("unexpected_tag", 64'(bus.done_tag_o), 64'hFFFF);
        else                       chk("done_tag", 64'(bus.done_tag_o), 64'(tag_exp_q.pop_front()));
      end
    end
  end

  // Caller sits just after a posedge; returns just after the accepting posedge.
  task automatic send_op(input logic [NR-1:0] m, input logic [NR*AW-1:0] base, input logic [AW-1:0] imm,
                         input logic [TW-1:0] tag, input logic we, input logic [31:0] wd,
                         input logic [31:0] wdth, input logic [IDW-1:0] eid, input logic [NR*AW-1:0] eaddr);
    exp_t e;
    bit   ok = 1'b0;
    bus.warp_valid_i = 1'b1;
    bus.warp_mask_i  = m;
    bus.warp_base_i  = base;
    bus.warp_imm_i   = imm;
    bus.warp_tag_i   = tag;
    bus.warp_we_i    = we;
    bus.warp_wdata_i = wd;
    bus.warp_width_i = wdth;
    if (m != '0) begin
      e.id = eid; e.mask = m; e.addr = eaddr; e.we = we; e.wdata = wd; e.width = wdth;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (bus.warp_ready_o) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.warp_valid_i = 1'b0;
    bus.warp_mask_i  = '0;
    if (!ok) chk("op_accept_timeout", 64'h0, 64'h1);
  endtask

  task automatic do_done(input logic [IDW-1:0] id, input logic [TW-1:0] etag, input logic eerr);
    bus.done_valid_i = 1'b1;
    bus.done_id_i    = id;
    if (!eerr) tag_exp_q.push_back(etag);
    @(posedge clk); #1;
    bus.done_valid_i = 1'b0;
    @(negedge clk);
    chk("done_error", 64'(bus.error_o), 64'(eerr));
    chk("done_tag_valid", 64'(bus.done_tag_valid_o), 64'(!eerr));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.warp_valid_i = 1'b0; bus.warp_we_i = 1'b0; bus.warp_tag_i = '0; bus.warp_mask_i = '0;
    bus.warp_base_i = '0; bus.warp_imm_i = '0; bus.warp_wdata_i = '0; bus.warp_width_i = '0;
    bus.req_ready_i = 1'b1; bus.done_valid_i = 1'b0; bus.done_id_i = '0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    bus.warp_valid_i = 1'b1; bus.warp_mask_i = 4'hF;
    @(negedge clk);
    chk("rst_warp_ready", 64'(bus.warp_ready_o), 64'h0);
    chk("rst_req_valid", 64'(bus.req_valid_o), 64'h0);
    chk("rst_outstanding", 64'(bus.outstanding_o), 64'h0);
    chk("rst_done_tag_valid", 64'(bus.done_tag_valid_o), 64'h0);
    chk("rst_error", 64'(bus.error_o), 64'h0);
    bus.warp_valid_i = 1'b0; bus.warp_mask_i = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Address add, ID allocation, wrap and negative immediate
    send_op(4'b1011, {8'h10, 8'h20, 8'h30, 8'h40}, 8'h05, 5'h01, 1'b0, 32'h0, 32'h0, 8'd0,
            {8'h15, 8'h25, 8'h35, 8'h45});
    chk("t1_outstanding", 64'(bus.outstanding_o), 64'd1);
    send_op(4'b1111, {8'hFE, 8'h00, 8'h80, 8'h7F}, 8'h04, 5'h02, 1'b1, 32'hDEADBEEF, 32'h4, 8'd1,
            {8'h02, 8'h04, 8'h84, 8'h83});
    send_op(4'b1111, {8'h00, 8'h01, 8'h10, 8'hFF}, 8'hFF, 5'h03, 1'b0, 32'h0, 32'h0, 8'd2,
            {8'hFF, 8'h00, 8'h0F, 8'hFE});
    chk("t2_outstanding", 64'(bus.outstanding_o), 64'd3);
    do_done(8'd0, 5'h01, 1'b0);
    do_done(8'd1, 5'h02, 1'b0);
    do_done(8'd2, 5'h03, 1'b0);
    chk("t2_drain_outstanding", 64'(bus.outstanding_o), 64'd0);

    // Fill the pool
    for (int i = 0; i < 16; i++) begin
      send_op(4'b0001, {24'h0, 8'(i)}, 8'h10, 5'(i + 4), 1'b0, 32'h0, 32'h0, 8'(i),
              {8'h10, 8'h10, 8'h10, 8'(i + 16)});
    end
    chk("t3_full_outstanding", 64'(bus.outstanding_o), 64'd16);
    bus.warp_valid_i = 1'b1; bus.warp_mask_i = 4'b0100;
    bus.warp_base_i = {8'h00, 8'h50, 8'h00, 8'h00}; bus.warp_imm_i = 8'h01;
    bus.warp_tag_i = 5'h1F; bus.warp_we_i = 1'b0;
    @(negedge clk);
    chk("t3_full_ready", 64'(bus.warp_ready_o), 64'h0);
    @(posedge clk); #1;
    bus.done_valid_i = 1'b1; bus.done_id_i = 8'd3;
    tag_exp_q.push_back(5'h07);
    @(negedge clk);
    chk("t3_ready_in_done_cycle", 64'(bus.warp_ready_o), 64'h0);
    @(posedge clk); #1;
    bus.done_valid_i = 1'b0;
    exp_q.push_back('{id: 8'd3, mask: 4'b0100, addr: {8'h01, 8'h51, 8'h01, 8'h01},
                      we: 1'b0, wdata: 32'h0, width: 32'h0});
    @(negedge clk);
    chk("t3_ready_after_free", 64'(bus.warp_ready_o), 64'h1);
    chk("t3_done_tag_valid", 64'(bus.done_tag_valid_o), 64'h1);
    @(posedge clk); #1;
    bus.warp_valid_i = 1'b0; bus.warp_mask_i = '0;
    chk("t3_refill_outstanding", 64'(bus.outstanding_o), 64'd16);

    // Zero mask accepted with pool full; bad completions
    send_op(4'b0000, 32'h12345678, 8'h00, 5'h0A, 1'b0, 32'h0, 32'h0, 8'd0, 32'h0);
    @(negedge clk);
    chk("t5_zero_mask_no_req", 64'(bus.req_valid_o), 64'h0);
    chk("t5_zero_mask_outstanding", 64'(bus.outstanding_o), 64'd16);
    @(posedge clk); #1;
    do_done(8'd9, 5'h0D, 1'b0);
    chk("t5_free9_outstanding", 64'(bus.outstanding_o), 64'd15);
    do_done(8'd9, 5'h00, 1'b1);
    do_done(8'd200, 5'h00, 1'b1);
    chk("t5_err_outstanding", 64'(bus.outstanding_o), 64'd15);
    do_done(8'd0, 5'h04, 1'b0);
    do_done(8'd1, 5'h05, 1'b0);
    chk("t5_free01_outstanding", 64'(bus.outstanding_o), 64'd13);

    // Backpressure hold
    bus.req_ready_i = 1'b0;
    send_op(4'b1111, {8'hA0, 8'hB0, 8'hC0, 8'hD0}, 8'h0F, 5'h11, 1'b1, 32'hCAFEF00D, 32'h2, 8'd0,
            {8'hAF, 8'hBF, 8'hCF, 8'hDF});
    chk("t4_outstanding", 64'(bus.outstanding_o), 64'd14);
    bus.warp_valid_i = 1'b1; bus.warp_mask_i = 4'b0011;
    bus.warp_base_i = {8'h00, 8'h00, 8'h01, 8'h02}; bus.warp_imm_i = 8'hFE;
    bus.warp_tag_i = 5'h12; bus.warp_we_i = 1'b0; bus.warp_wdata_i = 32'h0; bus.warp_width_i = 32'h0;
    exp_q.push_back('{id: 8'd1, mask: 4'b0011, addr: {8'hFE, 8'hFE, 8'hFF, 8'h00},
                      we: 1'b0, wdata: 32'h0, width: 32'h0});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_ready", 64'(bus.warp_ready_o), 64'h0);
      chk("t4_hold_valid", 64'(bus.req_valid_o), 64'h1);
      chk("t4_hold_id", 64'(bus.req_id_o), 64'h0);
      chk("t4_hold_addr", 64'(bus.req_addr_o), 64'hAFBFCFDF);
      chk("t4_hold_wdata", 64'(bus.req_wdata_o), 64'hCAFEF00D);
      chk("t4_hold_outstanding", 64'(bus.outstanding_o), 64'd14);
      @(posedge clk); #1;
    end
    bus.req_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_release_ready", 64'(bus.warp_ready_o), 64'h1);
    @(posedge clk); #1;
    bus.warp_valid_i = 1'b0; bus.warp_mask_i = '0;
    chk("t4_release_outstanding", 64'(bus.outstanding_o), 64'd15);

    // Reset mid-operation
    @(posedge clk); #1;
    bus.req_ready_i = 1'b0;
    send_op(4'b1000, {8'h01, 24'h0}, 8'h01, 5'h13, 1'b0, 32'h0, 32'h0, 8'd9,
            {8'h02, 8'h01, 8'h01, 8'h01});
    chk("t6_pre_outstanding", 64'(bus.outstanding_o), 64'd16);
    @(negedge clk);
    chk("t6_pre_valid", 64'(bus.req_valid_o), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.req_valid_o), 64'h0);
    chk("t6_rst_addr", 64'(bus.req_addr_o), 64'h0);
    chk("t6_rst_mask", 64'(bus.req_addr_valid_o), 64'h0);
    chk("t6_rst_outstanding", 64'(bus.outstanding_o), 64'h0);
    chk("t6_rst_ready", 64'(bus.warp_ready_o), 64'h0);
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_ready_i = 1'b1;
    send_op(4'b0001, {24'h0, 8'h20}, 8'h01, 5'h14, 1'b0, 32'h0, 32'h0, 8'd0,
            {8'h01, 8'h01, 8'h01, 8'h21});
    chk("t6_post_outstanding", 64'(bus.outstanding_o), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("end_req_queue_empty", 64'(exp_q.size()), 64'h0);
    chk("end_tag_queue_empty", 64'(tag_exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
